// File: rtl/serial_adder_16b_pkg.sv
// Shared constants and state encoding for the bit-serial 16-bit adder.
package serial_adder_16b_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } stateT;

endpackage : serial_adder_16b_pkg

// File: rtl/serial_adder_16b_fullAdder_1b.sv
// One-bit full-adder cell; the serial adder pushes one bit through it per cycle.
module fullAdder_1b (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic s,
  output logic cOut
);

  // Sum and carry of three one-bit inputs.
  always_comb begin
    s    = a ^ b ^ cIn;
    cOut = (a & b) | (cIn & (a ^ b));
  end

endmodule : fullAdder_1b

// File: rtl/serial_adder_16b.sv
// Bit-serial adder: LSB-first through one full-adder cell, WIDTH cycles per add,
// result and flags registered on entry to DONE and held until the next DONE.
module serial_adder_16b
  import serial_adder_16b_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ofl
);

  localparam int CntW = $clog2(WIDTH);

  stateT            state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] partSum;
  logic             carry;
  logic [CntW-1:0]  count;

  logic             cellSum;
  logic             cellCout;
  logic             lastBit;
  logic             msbCarryIn;
  logic [WIDTH-1:0] partSumNext;

  fullAdder_1b uCell (
    .a    (aReg[0]),
    .b    (bReg[0]),
    .cIn  (carry),
    .s    (cellSum),
    .cOut (cellCout)
  );

  // Datapath next values: the cell's sum bit enters at the MSB so the result
  // lands right-aligned after WIDTH shifts. On the last bit, the carry into
  // the cell is the carry into the MSB, which feeds the overflow flag.
  always_comb begin
    lastBit     = (count == CntW'(WIDTH - 1));
    msbCarryIn  = carry;
    partSumNext = {cellSum, partSum[WIDTH-1:1]};
  end

  // FSM and all registers; outputs are loaded directly so they never glitch.
  // NOTE: every flop here uses <= so all registers update from the same
  // pre-edge values; blocking assignments would let later lines see new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aReg    <= '0;
      bReg    <= '0;
      partSum <= '0;
      carry   <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ofl     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg  <= a;
            bReg  <= b;
            carry <= c_in;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          aReg    <= aReg >> 1;
          bReg    <= bReg >> 1;
          partSum <= partSumNext;
          carry   <= cellCout;
          if (lastBit) begin
            // Counter holds at WIDTH-1 rather than wrapping; it is cleared on
            // the next accepted start.
            sum   <= partSumNext;
            c_out <= cellCout;
            ofl   <= msbCarryIn ^ cellCout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count + CntW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder_16b

// File: tb/tb_serial_adder_16b.sv
// Self-checking bench for serial_adder_16b against an arithmetic reference model.
module tb_serial_adder_16b;

  localparam int W      = 16;
  localparam int LAT    = W + 1;   // edges from accept edge to done, inclusive
  localparam int PERIOD = W + 2;   // spacing of accepted starts

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } resT;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ofl;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  serial_adder_16b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ofl   (ofl)
  );

  // Reference: plain unsigned and signed integer addition.
  function automatic resT model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    resT         r;
    int unsigned total;
    int          stot;
    total = int'(x) + int'(y) + int'(ci);
    stot  = int'($signed(x)) + int'($signed(y)) + int'(ci);
    r.s   = total[W-1:0];
    r.co  = total[W];
    r.ov  = (stot > 32767) || (stot < -32768);
    return r;
  endfunction

  // Drives one operation and waits (bounded) for done. Operands are forced to
  // all-ones before edge changeAt (0 = never) to probe input isolation.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input int changeAt, output resT got, output int lat,
                        output bit found, output bit stableOk);
    resT prev;
    prev     = {sum, c_out, ofl};
    found    = 0;
    stableOk = 1;
    lat      = 0;
    got      = '0;
    a = x; b = y; c_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40 && !found; n++) begin
      if (n == changeAt) begin
        a = '1; b = '1; c_in = 1'b1;
      end
      @(posedge clk); #1;
      if (done) begin
        found = 1;
        lat   = n + 1;
        got   = {sum, c_out, ofl};
      end else if ({sum, c_out, ofl} !== prev || busy !== 1'b1) begin
        stableOk = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'hABCD; b = 16'h1234; c_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, sum, c_out, ofl} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {busy, done, sum, c_out, ofl});
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hold: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] xs[4] = '{16'h0001, 16'h7FFF, 16'h8000, 16'h1234};
    logic [W-1:0] ys[4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h4321};
    logic         cs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    resT          want[4] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1},
                              {16'h0000, 1'b1, 1'b1}, {16'h5556, 1'b0, 1'b0}};
    resT got;
    int  lat;
    bit  found, stableOk;
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], ys[i], cs[i], 0, got, lat, found, stableOk);
      vectors++;
      if (!found) begin
        errors++;
        $display("FAIL directed_%0d_timeout: no done within 40 cycles", i);
      end else if (got !== want[i] || lat != LAT || !stableOk) begin
        errors++;
        $display("FAIL directed_%0d: got %h lat %0d stable %0d required %h lat %0d stable 1",
                 i, got, lat, stableOk, want[i], LAT);
      end
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d_return_idle: busy=%b done=%b required 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_input_change();
    resT got;
    int  lat;
    bit  found, stableOk;
    run_op(16'h1234, 16'h4321, 1'b1, 4, got, lat, found, stableOk);
    vectors++;
    if (!found || got !== resT'({16'h5556, 1'b0, 1'b0})) begin
      errors++;
      $display("FAIL input_change: found %0d got %h required %h", found, got,
               resT'({16'h5556, 1'b0, 1'b0}));
    end
  endtask

  task automatic test_random();
    resT          got, want;
    logic [W-1:0] x, y;
    logic         ci;
    int           lat, chg;
    bit           found, stableOk;
    for (int i = 0; i < 24; i++) begin
      x    = W'($urandom);
      y    = W'($urandom);
      ci   = 1'($urandom);
      chg  = (i % 3 == 0) ? int'($urandom_range(1, 15)) : 0;
      want = model(x, y, ci);
      run_op(x, y, ci, chg, got, lat, found, stableOk);
      vectors++;
      if (!found || got !== want || lat != LAT || !stableOk) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h c_in=%b: found %0d got %h lat %0d stable %0d required %h lat %0d",
                 i, x, y, ci, found, got, lat, stableOk, want, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  doneAt[$];
    resT want;
    bit  resOk;
    bit  drained;
    want  = model(16'hC3A5, 16'h5A5A, 1'b1);
    resOk = 1;
    a = 16'hC3A5; b = 16'h5A5A; c_in = 1'b1; start = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk); #1;
      if (done) begin
        doneAt.push_back(e);
        if ({sum, c_out, ofl} !== want) resOk = 0;
      end
    end
    start = 1'b0;
    vectors++;
    if (doneAt.size() < 3 || !resOk) begin
      errors++;
      $display("FAIL back_to_back_pulses: %0d pulses result_ok %0d required >=3 and 1",
               doneAt.size(), resOk);
    end
    for (int i = 1; i < doneAt.size(); i++) begin
      vectors++;
      if (doneAt[i] - doneAt[i-1] != PERIOD) begin
        errors++;
        $display("FAIL back_to_back_spacing_%0d: got %0d required %0d",
                 i, doneAt[i] - doneAt[i-1], PERIOD);
      end
    end
    drained = 0;
    for (int n = 0; n < 40 && !drained; n++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) drained = 1;
    end
    vectors++;
    if (!drained) begin
      errors++;
      $display("FAIL back_to_back_drain: busy still %b after 40 cycles, required 0", busy);
    end
  endtask

  task automatic test_ignore_start();
    resT want, got;
    int  dones;
    want  = model(16'h0F0F, 16'h00F1, 1'b0);
    dones = 0;
    got   = '0;
    a = 16'h0F0F; b = 16'h00F1; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      start = (n <= 15) ? 1'(n % 2) : 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      if (done) begin
        dones++;
        got = {sum, c_out, ofl};
      end
    end
    vectors++;
    if (dones != 1 || got !== want || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: dones %0d got %h busy %b required 1 %h 0",
               dones, got, busy, want);
    end
  endtask

  task automatic test_reset_abort();
    resT          got, want;
    logic [W-1:0] x, y;
    int           lat, dones;
    bit           found, stableOk;
    run_op(16'h1234, 16'h4321, 1'b1, 0, got, lat, found, stableOk);
    a = 16'hFFFF; b = 16'h0003; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, sum, c_out, ofl} !== '0) begin
      errors++;
      $display("FAIL reset_abort_clear: got %h required 0", {busy, done, sum, c_out, ofl});
    end
    rst   = 1'b0;
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    vectors++;
    if (dones != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_no_done: dones %0d busy %b required 0 0", dones, busy);
    end
    x    = W'($urandom);
    y    = W'($urandom);
    want = model(x, y, 1'b1);
    run_op(x, y, 1'b1, 0, got, lat, found, stableOk);
    vectors++;
    if (!found || got !== want || lat != LAT) begin
      errors++;
      $display("FAIL reset_abort_restart: found %0d got %h lat %0d required %h lat %0d",
               found, got, lat, want, LAT);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    test_reset();
    test_directed();
    test_input_change();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_serial_adder_16b
